// File: rtl/fetch_mem_if.sv
// fetch_mem_if: instruction-side memory interface for the fetch unit.
// Each cycle it looks up three words: the opcode at pc, the argument at pc+2
// and the prefetch opcode at pf. Lookups go to a small fully-associative
// buffer of 16-bit words. Misses are filled one word at a time over a req/ack
// read port. hold is raised until all three words are buffered and no fill
// is in flight.
// Optional feature: define FETCH_STATS_EN to add the stat_hits/stat_misses
// counters. Without it the ports and counters are absent.
module fetch_mem_if #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic [15:0] pc_addr,
  input  logic [15:0] pf_addr,
  input  logic        flush,
  output logic [15:0] fetch_opc,
  output logic [15:0] fetch_arg,
  output logic [15:0] prefetch_opc,
  output logic        hold,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
`ifdef FETCH_STATS_EN
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  input  logic [15:0] mem_rdata
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned TAG_W = 15;
  localparam int unsigned DAT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;

  // Buffer storage: one word per entry, tagged by word address.
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [DAT_W-1:0] data_q  [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_W-1:0]   rr_q;

  // Set when a flush lands while a read is outstanding; its data is dropped.
  logic drop_q;

  // Word addresses of the three lookups; the argument address wraps at 64K.
  logic [TAG_W-1:0] opc_tag;
  logic [TAG_W-1:0] arg_tag;
  logic [TAG_W-1:0] pre_tag;

  assign opc_tag = pc_addr[15:1];
  assign arg_tag = pc_addr[15:1] + TAG_W'(1);
  assign pre_tag = pf_addr[15:1];

  // Byte-select bits of the lookup addresses carry no information here.
  logic unused_bits;
  assign unused_bits = ^{pc_addr[0], pf_addr[0]};

  logic [ENTRIES-1:0] opc_hv;
  logic [ENTRIES-1:0] arg_hv;
  logic [ENTRIES-1:0] pre_hv;
  logic [ENTRIES-1:0] locked;

  // Tag compare of every valid entry against the three lookup addresses.
  always_comb begin
    opc_hv = '0;
    arg_hv = '0;
    pre_hv = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      opc_hv[i] = valid_q[i] && (tag_q[i] == opc_tag);
      arg_hv[i] = valid_q[i] && (tag_q[i] == arg_tag);
      pre_hv[i] = valid_q[i] && (tag_q[i] == pre_tag);
    end
  end

  assign locked = opc_hv | arg_hv | pre_hv;

  // AND-OR read mux; a tag is never buffered twice, so at most one hit each.
  always_comb begin
    fetch_opc    = '0;
    fetch_arg    = '0;
    prefetch_opc = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      fetch_opc    = fetch_opc    | ({DAT_W{opc_hv[i]}} & data_q[i]);
      fetch_arg    = fetch_arg    | ({DAT_W{arg_hv[i]}} & data_q[i]);
      prefetch_opc = prefetch_opc | ({DAT_W{pre_hv[i]}} & data_q[i]);
    end
  end

  logic miss_opc;
  logic miss_arg;
  logic miss_pre;
  logic any_miss;
  logic [TAG_W-1:0] miss_tag;

  assign miss_opc = ~|opc_hv;
  assign miss_arg = ~|arg_hv;
  assign miss_pre = ~|pre_hv;
  assign any_miss = miss_opc | miss_arg | miss_pre;

  // First missing word, opcode before argument before prefetch.
  always_comb begin
    miss_tag = pre_tag;
    if (miss_opc) begin
      miss_tag = opc_tag;
    end else if (miss_arg) begin
      miss_tag = arg_tag;
    end
  end

  assign hold = any_miss | (state == BUSY);

  logic [IDX_W-1:0] victim;
  logic [IDX_W-1:0] cand;
  logic             vic_found;

  // Victim: lowest free entry, else first unlocked entry from the rr pointer.
  always_comb begin
    victim    = '0;
    cand      = '0;
    vic_found = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!vic_found && !valid_q[i]) begin
        victim    = IDX_W'(i);
        vic_found = 1'b1;
      end
    end
    for (int k = 0; k < int'(ENTRIES); k++) begin
      cand = IDX_W'((int'(rr_q) + k) % int'(ENTRIES));
      if (!vic_found && !locked[cand]) begin
        victim    = cand;
        vic_found = 1'b1;
      end
    end
  end

  logic fill_write;
  assign fill_write = (state == BUSY) && mem_ack && !drop_q && !flush;

  // Fill FSM: issue one read per missing word and wait for its ack.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      drop_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_miss && !flush) begin
            mem_addr <= {miss_tag, 1'b0};
            mem_req  <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            drop_q <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            drop_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer update: flush clears every entry and overrides a same-cycle fill.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      valid_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_write) begin
      tag_q[victim]   <= mem_addr[15:1];
      data_q[victim]  <= mem_rdata;
      valid_q[victim] <= 1'b1;
      rr_q            <= IDX_W'((int'(victim) + 1) % int'(ENTRIES));
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating counters of fully-hit idle cycles and issued reads.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == IDLE) begin
      if (!any_miss && (stat_hits != 16'hFFFF)) begin
        stat_hits <= stat_hits + 16'd1;
      end
      if (any_miss && !flush && (stat_misses != 16'hFFFF)) begin
        stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_if.sv
// Testbench for fetch_mem_if: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a word-level model of the buffer.
module tb_fetch_mem_if;

  localparam int NE = 4;

  logic        clk = 1'b0;
  logic        a_rst;
  logic [15:0] pc_addr;
  logic [15:0] pf_addr;
  logic        flush;
  logic [15:0] fetch_opc;
  logic [15:0] fetch_arg;
  logic [15:0] prefetch_opc;
  logic        hold;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
`endif

  fetch_mem_if #(.ENTRIES(NE)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .pc_addr      (pc_addr),
    .pf_addr      (pf_addr),
    .flush        (flush),
    .fetch_opc    (fetch_opc),
    .fetch_arg    (fetch_arg),
    .prefetch_opc (prefetch_opc),
    .hold         (hold),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
`ifdef FETCH_STATS_EN
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
`endif
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory image, word addressed; words are non-zero so a hit differs from 0.
  logic [15:0] mem [32768];

  // Model: buffered words as (tag, data) slots, plus the one outstanding read.
  logic [14:0] m_tag [NE];
  logic [15:0] m_dat [NE];
  bit          m_val [NE];
  int          m_rr;
  bit          m_busy;
  bit          m_drop;
  logic [14:0] m_addr;
  int          m_bcnt;
  int          m_hits;
  int          m_reqs;

  int lat;
  int errors = 0;
  int checks = 0;

  logic [65:0] obs;
  logic [65:0] exp_v;
  bit          prev_req;
  logic [15:0] req_log [$];
  int          hold_cnt;

  function automatic int m_find(input logic [14:0] t);
    int r = -1;
    for (int i = 0; i < NE; i++) if (r < 0 && m_val[i] && m_tag[i] == t) r = i;
    return r;
  endfunction

  function automatic logic [15:0] m_word(input logic [14:0] t);
    int s = m_find(t);
    return (s < 0) ? 16'h0000 : m_dat[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_val[i] = 1'b0;
      m_tag[i] = '0;
      m_dat[i] = '0;
    end
    m_rr = 0; m_busy = 0; m_drop = 0; m_addr = '0; m_bcnt = 0;
    m_hits = 0; m_reqs = 0; prev_req = 0;
  endtask

  // New word goes to a free slot, else the first slot from rr that none of
  // the three current lookups is using.
  task automatic m_insert(input logic [14:0] t, input logic [15:0] d,
                          input logic [14:0] a, input logic [14:0] b, input logic [14:0] c);
    int v = -1;
    for (int i = 0; i < NE; i++) if (v < 0 && !m_val[i]) v = i;
    for (int k = 0; k < NE; k++) begin
      int s = (m_rr + k) % NE;
      if (v < 0 && m_tag[s] != a && m_tag[s] != b && m_tag[s] != c) v = s;
    end
    if (v >= 0) begin
      m_tag[v] = t; m_dat[v] = d; m_val[v] = 1'b1;
      m_rr = (v + 1) % NE;
    end
  endtask

  // One clock: drive memory response, sample at negedge, advance the model.
  task automatic step();
    logic [14:0] to, ta, tp;
    bit mo, ma, mp;
    to = pc_addr[15:1];
    ta = to + 15'd1;
    tp = pf_addr[15:1];
    mem_ack   = m_busy && (m_bcnt >= lat);
    mem_rdata = mem_ack ? mem[mem_addr[15:1]] : 16'($urandom);
    @(negedge clk);
    mo = m_find(to) < 0;
    ma = m_find(ta) < 0;
    mp = m_find(tp) < 0;
    obs   = {fetch_opc, fetch_arg, prefetch_opc, hold, mem_req, mem_addr};
    exp_v = {m_word(to), m_word(ta), m_word(tp), mo | ma | mp | m_busy, m_busy, m_addr, 1'b0};
    if (hold) hold_cnt++;
    if (mem_req && !prev_req) req_log.push_back(mem_addr);
    prev_req = mem_req;
    @(posedge clk);
    if (!m_busy) begin
      if (!(mo | ma | mp)) m_hits++;
      else if (!flush) begin
        m_busy = 1; m_bcnt = 0; m_reqs++;
        m_addr = mo ? to : (ma ? ta : tp);
      end
    end else begin
      if (flush) m_drop = 1;
      if (mem_ack) begin
        if (!m_drop) m_insert(m_addr, mem[m_addr], to, ta, tp);
        m_busy = 0; m_drop = 0;
      end else begin
        m_bcnt++;
      end
    end
    if (flush) for (int i = 0; i < NE; i++) m_val[i] = 1'b0;
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic start_log();
    req_log.delete();
    hold_cnt = 0;
  endtask

  task automatic test_reset();
    a_rst = 1'b0; pc_addr = 16'h0100; pf_addr = 16'h0102; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; lat = 0;
    m_reset();
    repeat (2) @(negedge clk);
    checks++; if (fetch_opc !== 16'h0) begin errors++; $display("FAIL reset_opc got %h want 0000", fetch_opc); end
    checks++; if (fetch_arg !== 16'h0) begin errors++; $display("FAIL reset_arg got %h want 0000", fetch_arg); end
    checks++; if (prefetch_opc !== 16'h0) begin errors++; $display("FAIL reset_pre got %h want 0000", prefetch_opc); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %b want 1", hold); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    @(posedge clk); #1;
    a_rst = 1'b1;
  endtask

  task automatic test_cold_fill();
    start_log();
    lat = 0; pc_addr = 16'h0100; pf_addr = 16'h0102;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL cold_fill c%0d got %h want %h", c, obs, exp_v); end
    end
    checks++; if (req_log.size() != 2 || req_log[0] !== 16'h0100 || req_log[1] !== 16'h0102) begin
      errors++; $display("FAIL cold_reqs got n=%0d first=%h want 0100,0102", req_log.size(), req_log.size() ? req_log[0] : 16'hxxxx);
    end
    checks++; if (hold_cnt != 4) begin errors++; $display("FAIL cold_hold_cycles got %0d want 4", hold_cnt); end
    checks++; if (fetch_arg !== mem[16'h0081]) begin errors++; $display("FAIL cold_arg got %h want %h", fetch_arg, mem[16'h0081]); end
  endtask

  task automatic test_warm_seq();
    start_log();
    pc_addr = 16'h0102; pf_addr = 16'h0104;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL warm c%0d got %h want %h", c, obs, exp_v); end
    end
    checks++; if (req_log.size() != 1 || req_log[0] !== 16'h0104) begin
      errors++; $display("FAIL warm_reqs got n=%0d want one at 0104", req_log.size());
    end
    checks++; if (hold_cnt != 2) begin errors++; $display("FAIL warm_hold_cycles got %0d want 2", hold_cnt); end
  endtask

  task automatic test_wrap();
    start_log();
    pc_addr = 16'hFFFE; pf_addr = 16'h0000;
    for (int c = 0; c < 7; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap c%0d got %h want %h", c, obs, exp_v); end
    end
    checks++; if (req_log.size() != 2 || req_log[0] !== 16'hFFFE || req_log[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_reqs got n=%0d want FFFE,0000", req_log.size());
    end
    checks++; if (fetch_arg !== mem[0] || prefetch_opc !== mem[0]) begin
      errors++; $display("FAIL wrap_data got arg=%h pre=%h want %h", fetch_arg, prefetch_opc, mem[0]);
    end
  endtask

  task automatic test_wait_states();
    start_log();
    lat = 3; pc_addr = 16'h0102; pf_addr = 16'h0106;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL wait c%0d got %h want %h", c, obs, exp_v); end
    end
    checks++; if (req_log.size() != 1 || req_log[0] !== 16'h0106) begin
      errors++; $display("FAIL wait_reqs got n=%0d want one at 0106", req_log.size());
    end
    checks++; if (hold_cnt != 5) begin errors++; $display("FAIL wait_hold_cycles got %0d want 5", hold_cnt); end
    lat = 0;
  endtask

  task automatic test_flush_ack();
    start_log();
    lat = 2; pc_addr = 16'h0300; pf_addr = 16'h0300;
    for (int c = 0; c < 4; c++) begin
      flush = (c == 3);
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL flush c%0d got %h want %h", c, obs, exp_v); end
    end
    flush = 1'b0; lat = 0; pf_addr = 16'h0102;
    step();
    checks++; if ({fetch_opc, fetch_arg, prefetch_opc, hold} !== {48'h0, 1'b1}) begin
      errors++; $display("FAIL flush_empty got %h %h %h hold=%b want 0 0 0 hold=1", fetch_opc, fetch_arg, prefetch_opc, hold);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL flush_refill c%0d got %h want %h", c, obs, exp_v); end
    end
    checks++; if (req_log.size() < 2 || req_log[0] !== 16'h0300 || req_log[1] !== 16'h0300) begin
      errors++; $display("FAIL flush_refetch got n=%0d want 0300 twice", req_log.size());
    end
  endtask

  task automatic test_replacement();
    lat = 0;
    for (int p = 0; p < 6; p++) begin
      start_log();
      pc_addr = 16'(16'h1000 + p * 16'h10);
      pf_addr = 16'(16'h2000 + p * 16'h10);
      for (int c = 0; c < 8; c++) begin
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL repl p%0d c%0d got %h want %h", p, c, obs, exp_v); end
      end
      checks++; if (hold !== 1'b0 || req_log.size() != 3) begin
        errors++; $display("FAIL repl_settle p%0d got hold=%b reqs=%0d want hold=0 reqs=3", p, hold, req_log.size());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 16'(16'h4000 + 2 * i);
    pool[7] = 16'hFFFE;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) pc_addr = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) pf_addr = pool[$urandom_range(0, 7)] | 16'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      if (!m_busy) lat = $urandom_range(0, 3);
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL random c%0d got %h want %h", c, obs, exp_v); end
    end
    flush = 1'b0;
  endtask

  task automatic test_stats();
`ifdef FETCH_STATS_EN
    checks++; if (stat_hits !== 16'(m_hits)) begin errors++; $display("FAIL stat_hits got %0d want %0d", stat_hits, m_hits); end
    checks++; if (stat_misses !== 16'(m_reqs)) begin errors++; $display("FAIL stat_misses got %0d want %0d", stat_misses, m_reqs); end
`endif
  endtask

  task automatic test_mid_fill_reset();
    lat = 3; pc_addr = 16'h0500; pf_addr = 16'h0500;
    step();
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_busy got req=%b want 1", mem_req); end
    a_rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || hold !== 1'b1 || fetch_opc !== 16'h0) begin
      errors++; $display("FAIL midrst_async got req=%b hold=%b opc=%h want 0 1 0000", mem_req, hold, fetch_opc);
    end
    m_reset();
    @(posedge clk); #1;
    a_rst = 1'b1; lat = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL midrst_refill c%0d got %h want %h", c, obs, exp_v); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == 16'h0) mem[i] = 16'h0001;
    end
    test_reset();
    test_cold_fill();
    test_warm_seq();
    test_wrap();
    test_wait_states();
    test_flush_ack();
    test_replacement();
    test_random();
    test_stats();
    test_mid_fill_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
